// File: rtl/axi4lite_cmd_master.sv
// AXI4-Lite master for the IIC register port: one command in, one AXI transaction out,
// one response back. At most one transaction outstanding, with an optional hung-slave timeout.
module axi4lite_cmd_master #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  // command / response side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  // AXI4-Lite master
  output logic [ADDR_W-1:0]   s_axi_awaddr,
  output logic                s_axi_awvalid,
  input  logic                s_axi_awready,
  output logic [DATA_W-1:0]   s_axi_wdata,
  output logic [DATA_W/8-1:0] s_axi_wstrb,
  output logic                s_axi_wvalid,
  input  logic                s_axi_wready,
  input  logic [1:0]          s_axi_bresp,
  input  logic                s_axi_bvalid,
  output logic                s_axi_bready,
  output logic [ADDR_W-1:0]   s_axi_araddr,
  output logic                s_axi_arvalid,
  input  logic                s_axi_arready,
  input  logic [DATA_W-1:0]   s_axi_rdata,
  input  logic [1:0]          s_axi_rresp,
  input  logic                s_axi_rvalid,
  output logic                s_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             aw_fin, w_fin, busy, progress, timeout_hit, abort;

  // AW and W channels are finished once their valid is low or handshaking this edge.
  assign aw_fin  = !s_axi_awvalid || s_axi_awready;
  assign w_fin   = !s_axi_wvalid  || s_axi_wready;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign busy    = (state == WR_AW_W) || (state == WR_B) || (state == RD_AR) || (state == RD_R);

  // A real handshake landing on the timeout edge wins over the abort.
  always_comb begin
    progress = 1'b0;
    case (state)
      WR_AW_W: progress = aw_fin && w_fin;
      WR_B:    progress = s_axi_bvalid;
      RD_AR:   progress = s_axi_arready;
      RD_R:    progress = s_axi_rvalid;
      default: progress = 1'b0;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt >= TO_LAST);
  assign abort       = busy && timeout_hit && !progress;

  // NOTE: every output is a register and all state uses non-blocking assignments, so
  // downstream logic sees values that changed only at the clock edge, never mid-cycle.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= IDLE;
      cnt           <= '0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      rsp_timeout   <= 1'b0;
      s_axi_awaddr  <= '0;
      s_axi_awvalid <= 1'b0;
      s_axi_wdata   <= '0;
      s_axi_wstrb   <= '0;
      s_axi_wvalid  <= 1'b0;
      s_axi_bready  <= 1'b0;
      s_axi_araddr  <= '0;
      s_axi_arvalid <= 1'b0;
      s_axi_rready  <= 1'b0;
    end else begin
      if (busy) cnt <= cnt_inc;

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cnt       <= '0;
            if (cmd_write) begin
              state         <= WR_AW_W;
              s_axi_awaddr  <= cmd_addr;
              s_axi_wdata   <= cmd_wdata;
              s_axi_wstrb   <= cmd_wstrb;
              s_axi_awvalid <= 1'b1;
              s_axi_wvalid  <= 1'b1;
            end else begin
              state         <= RD_AR;
              s_axi_araddr  <= cmd_addr;
              s_axi_arvalid <= 1'b1;
            end
          end
        end

        WR_AW_W: begin
          if (s_axi_awvalid && s_axi_awready) s_axi_awvalid <= 1'b0;
          if (s_axi_wvalid && s_axi_wready)   s_axi_wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            state        <= WR_B;
            s_axi_bready <= 1'b1;
          end
        end

        WR_B: begin
          if (s_axi_bvalid) begin
            state        <= RSP;
            s_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_resp     <= s_axi_bresp;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b0;
          end
        end

        RD_AR: begin
          if (s_axi_arready) begin
            state         <= RD_R;
            s_axi_arvalid <= 1'b0;
            s_axi_rready  <= 1'b1;
          end
        end

        RD_R: begin
          if (s_axi_rvalid) begin
            state        <= RSP;
            s_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_resp     <= s_axi_rresp;
            rsp_rdata    <= s_axi_rdata;
            rsp_timeout  <= 1'b0;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // Hung-slave abort: deliberately drops the bus mid-transaction.
      if (abort) begin
        state         <= RSP;
        s_axi_awvalid <= 1'b0;
        s_axi_wvalid  <= 1'b0;
        s_axi_bready  <= 1'b0;
        s_axi_arvalid <= 1'b0;
        s_axi_rready  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_resp      <= 2'b10;
        rsp_rdata     <= '0;
        rsp_timeout   <= 1'b1;
      end
    end
  end

endmodule
